// File: rtl/pipeline_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller.
//   state_t : controller FSM states (RUN, MEM2, INT_DRAIN, INT_VEC)
//   PC_*    : pc_sel codes driven to the PC source mux
package pipeline_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_RUN       = 2'd0,
      ST_MEM2      = 2'd1,
      ST_INT_DRAIN = 2'd2,
      ST_INT_VEC   = 2'd3
   } state_t;

   localparam logic [1:0] PC_SEQ    = 2'b00;
   localparam logic [1:0] PC_BRANCH = 2'b01;
   localparam logic [1:0] PC_VECTOR = 2'b10;

endpackage

// File: rtl/load_use_detector.sv
// Load-use hazard compare between the load in DE and the sources of FD.
//   de_mem_read, de_reg_dst_num     : DE instruction is a load and its destination
//   fd_src{1,2}_num, fd_src{1,2}_used : FD source fields and their valid bits
//   hit_o                           : FD needs the value the DE load has not produced yet
module load_use_detector (
   input  logic       de_mem_read,
   input  logic [3:0] de_reg_dst_num,
   input  logic [2:0] fd_src1_num,
   input  logic [3:0] fd_src2_num,
   input  logic       fd_src1_used,
   input  logic       fd_src2_used,
   output logic       hit_o
);

   logic src1_match;
   logic src2_match;

   // Source 1 field is only 3 bits wide, so it can only alias the low registers.
   assign src1_match = fd_src1_used && ({1'b0, fd_src1_num} == de_reg_dst_num);
   assign src2_match = fd_src2_used && (fd_src2_num == de_reg_dst_num);
   assign hit_o      = de_mem_read && (src1_match || src2_match);

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Central pipeline sequencer: hold-enables and synchronous flushes for the
// FD/DE/EM/MW registers, PC write enable and PC source select.
//   clk, reset (active-low, async)
//   hazard inputs : load-use fields, branch_taken, mem_multi, int_req
//   outputs       : pc_en, pc_sel, *_en, *_flush, int_ack, ctrl_state
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   RUN       | normal issue; load-use stall, branch flush, mem_multi entry
//   MEM2      | second cycle of a two-cycle memory op, returns to ret_state
//   INT_DRAIN | fetch blocked, FD flushed, older instructions retire
//   INT_VEC   | PC loads the interrupt vector, int_ack pulses
module pipeline_hazard_controller
   import pipeline_ctrl_pkg::*;
#(
   parameter int DRAIN_CYCLES = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       de_mem_read,
   input  logic [3:0] de_reg_dst_num,
   input  logic [2:0] fd_src1_num,
   input  logic [3:0] fd_src2_num,
   input  logic       fd_src1_used,
   input  logic       fd_src2_used,
   input  logic       branch_taken,
   input  logic       mem_multi,
   input  logic       int_req,
   output logic       pc_en,
   output logic [1:0] pc_sel,
   output logic       fd_en,
   output logic       de_en,
   output logic       em_en,
   output logic       mw_en,
   output logic       fd_flush,
   output logic       de_flush,
   output logic       em_flush,
   output logic       mw_flush,
   output logic       int_ack,
   output logic [2:0] ctrl_state
);

   localparam logic [2:0] DRAIN_LOAD = 3'(DRAIN_CYCLES - 1);

   state_t     state_q, state_d;
   state_t     ret_q, ret_d;
   logic [2:0] cnt_q, cnt_d;
   logic       pend_q, pend_d;
   logic       lu_hit;

   load_use_detector u_lu (
      .de_mem_read    (de_mem_read),
      .de_reg_dst_num (de_reg_dst_num),
      .fd_src1_num    (fd_src1_num),
      .fd_src2_num    (fd_src2_num),
      .fd_src1_used   (fd_src1_used),
      .fd_src2_used   (fd_src2_used),
      .hit_o          (lu_hit)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_RUN;
         ret_q   <= ST_RUN;
         cnt_q   <= 3'd0;
         pend_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ret_q   <= ret_d;
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      ret_d    = ret_q;
      cnt_d    = cnt_q;
      pc_en    = 1'b1;
      pc_sel   = PC_SEQ;
      fd_en    = 1'b1;
      de_en    = 1'b1;
      em_en    = 1'b1;
      mw_en    = 1'b1;
      fd_flush = 1'b0;
      de_flush = 1'b0;
      em_flush = 1'b0;
      mw_flush = 1'b0;
      int_ack  = 1'b0;

      case (state_q)
         ST_RUN: begin
            if (mem_multi) begin
               pc_en    = 1'b0;
               fd_en    = 1'b0;
               de_en    = 1'b0;
               em_en    = 1'b0;
               mw_flush = 1'b1;
               ret_d    = ST_RUN;
               state_d  = ST_MEM2;
            end else begin
               if (branch_taken) begin
                  fd_flush = 1'b1;
                  de_flush = 1'b1;
                  pc_sel   = PC_BRANCH;
               end else if (lu_hit) begin
                  pc_en    = 1'b0;
                  fd_en    = 1'b0;
                  de_flush = 1'b1;
               end
               // Same-cycle int_req counts so entry latency is one cycle.
               if (pend_q || int_req) begin
                  state_d = ST_INT_DRAIN;
                  cnt_d   = DRAIN_LOAD;
               end
            end
         end
         ST_MEM2: begin
            // Second memory cycle during a drain still counts as a drain
            // cycle, so a two-cycle op only lengthens the drain by one.
            if (ret_q == ST_INT_DRAIN) begin
               pc_en    = 1'b0;
               fd_flush = 1'b1;
               if (cnt_q != 3'd0) cnt_d = cnt_q - 3'd1;
            end
            state_d = ret_q;
         end
         ST_INT_DRAIN: begin
            pc_en    = 1'b0;
            fd_flush = 1'b1;
            if (mem_multi) begin
               fd_en    = 1'b0;
               de_en    = 1'b0;
               em_en    = 1'b0;
               mw_flush = 1'b1;
               ret_d    = ST_INT_DRAIN;
               state_d  = ST_MEM2;
            end else begin
               if (branch_taken) begin
                  de_flush = 1'b1;
                  pc_sel   = PC_BRANCH;
                  pc_en    = 1'b1;
               end
               if (cnt_q == 3'd0) state_d = ST_INT_VEC;
               else               cnt_d   = cnt_q - 3'd1;
            end
         end
         ST_INT_VEC: begin
            pc_sel  = PC_VECTOR;
            int_ack = 1'b1;
            state_d = ST_RUN;
         end
         default: state_d = ST_RUN;
      endcase

      // A request arriving with the ack is kept so it is taken after RUN.
      pend_d = int_req || (pend_q && !int_ack);

      if (!reset) begin
         pc_en    = 1'b1;
         pc_sel   = PC_SEQ;
         fd_en    = 1'b1;
         de_en    = 1'b1;
         em_en    = 1'b1;
         mw_en    = 1'b1;
         fd_flush = 1'b0;
         de_flush = 1'b0;
         em_flush = 1'b0;
         mw_flush = 1'b0;
         int_ack  = 1'b0;
      end
   end

   assign ctrl_state = {1'b0, state_q};

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
module tb_pipeline_hazard_controller;

   logic       clk = 1'b0;
   logic       reset;
   logic       de_mem_read;
   logic [3:0] de_reg_dst_num;
   logic [2:0] fd_src1_num;
   logic [3:0] fd_src2_num;
   logic       fd_src1_used, fd_src2_used;
   logic       branch_taken, mem_multi, int_req;
   logic       pc_en;
   logic [1:0] pc_sel;
   logic       fd_en, de_en, em_en, mw_en;
   logic       fd_flush, de_flush, em_flush, mw_flush;
   logic       int_ack;
   logic [2:0] ctrl_state;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   pipeline_hazard_controller #(.DRAIN_CYCLES(3)) dut (
      .clk            (clk),
      .reset          (reset),
      .de_mem_read    (de_mem_read),
      .de_reg_dst_num (de_reg_dst_num),
      .fd_src1_num    (fd_src1_num),
      .fd_src2_num    (fd_src2_num),
      .fd_src1_used   (fd_src1_used),
      .fd_src2_used   (fd_src2_used),
      .branch_taken   (branch_taken),
      .mem_multi      (mem_multi),
      .int_req        (int_req),
      .pc_en          (pc_en),
      .pc_sel         (pc_sel),
      .fd_en          (fd_en),
      .de_en          (de_en),
      .em_en          (em_en),
      .mw_en          (mw_en),
      .fd_flush       (fd_flush),
      .de_flush       (de_flush),
      .em_flush       (em_flush),
      .mw_flush       (mw_flush),
      .int_ack        (int_ack),
      .ctrl_state     (ctrl_state)
   );

   // Expected word: {pc_en, pc_sel, fd/de/em/mw_en, fd/de/em/mw_flush, int_ack, ctrl_state}
   typedef struct {
      logic        mr;
      logic [3:0]  dst;
      logic [2:0]  s1;
      logic [3:0]  s2;
      logic        u1, u2, br, mm, irq;
      logic [14:0] exp;
   } vec_t;

   vec_t tbl[$];

   logic [14:0] E_DEF, E_LU, E_BR, E_MM, E_M2, E_D, E_DBR, E_DMM, E_M2D, E_VEC;

   function automatic logic [14:0] ex(input logic pe, input logic [1:0] ps,
                                      input logic [3:0] en, input logic [3:0] fl,
                                      input logic ack, input logic [2:0] st);
      return {pe, ps, en, fl, ack, st};
   endfunction

   function automatic logic [14:0] act();
      return {pc_en, pc_sel, fd_en, de_en, em_en, mw_en,
              fd_flush, de_flush, em_flush, mw_flush, int_ack, ctrl_state};
   endfunction

   task automatic add(input logic mr, input logic [3:0] dst, input logic [2:0] s1,
                      input logic [3:0] s2, input logic u1, input logic u2,
                      input logic br, input logic mm, input logic irq,
                      input logic [14:0] e);
      vec_t v;
      v.mr = mr; v.dst = dst; v.s1 = s1; v.s2 = s2; v.u1 = u1; v.u2 = u2;
      v.br = br; v.mm = mm; v.irq = irq; v.exp = e;
      tbl.push_back(v);
   endtask

   task automatic idle(input logic [14:0] e);
      add(0, 4'd0, 3'd0, 4'd0, 0, 0, 0, 0, 0, e);
   endtask

   task automatic drive(input vec_t v);
      de_mem_read = v.mr; de_reg_dst_num = v.dst; fd_src1_num = v.s1;
      fd_src2_num = v.s2; fd_src1_used = v.u1; fd_src2_used = v.u2;
      branch_taken = v.br; mem_multi = v.mm; int_req = v.irq;
   endtask

   task automatic check(input string name, input logic [14:0] e);
      checks++;
      if (act() !== e) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act(), e);
      end
   endtask

   initial begin
      vec_t z;
      E_DEF = ex(1, 2'b00, 4'b1111, 4'b0000, 0, 3'd0);
      E_LU  = ex(0, 2'b00, 4'b0111, 4'b0100, 0, 3'd0);
      E_BR  = ex(1, 2'b01, 4'b1111, 4'b1100, 0, 3'd0);
      E_MM  = ex(0, 2'b00, 4'b0001, 4'b0001, 0, 3'd0);
      E_M2  = ex(1, 2'b00, 4'b1111, 4'b0000, 0, 3'd1);
      E_D   = ex(0, 2'b00, 4'b1111, 4'b1000, 0, 3'd2);
      E_DBR = ex(1, 2'b01, 4'b1111, 4'b1100, 0, 3'd2);
      E_DMM = ex(0, 2'b00, 4'b0001, 4'b1001, 0, 3'd2);
      E_M2D = ex(0, 2'b00, 4'b1111, 4'b1000, 0, 3'd1);
      E_VEC = ex(1, 2'b10, 4'b1111, 4'b0000, 1, 3'd3);

      idle(E_DEF);
      add(1, 4'd2, 3'd2, 4'd0, 1, 0, 0, 0, 0, E_LU);    // load-use src1
      idle(E_DEF);                                      // single bubble only
      add(1, 4'd9, 3'd0, 4'd9, 0, 1, 0, 0, 0, E_LU);    // load-use src2
      add(1, 4'd9, 3'd1, 4'd9, 1, 0, 0, 0, 0, E_DEF);   // src1 cannot alias r9, src2 unused
      add(0, 4'd2, 3'd2, 4'd2, 1, 1, 0, 0, 0, E_DEF);   // not a load
      add(1, 4'd2, 3'd2, 4'd0, 1, 0, 1, 0, 0, E_BR);    // branch beats load-use
      add(0, 4'd0, 3'd0, 4'd0, 0, 0, 0, 1, 0, E_MM);    // mem_multi held 2 cycles
      add(0, 4'd0, 3'd0, 4'd0, 0, 0, 0, 1, 0, E_M2);
      idle(E_DEF);
      add(1, 4'd2, 3'd2, 4'd0, 1, 0, 1, 1, 0, E_MM);    // mem_multi beats branch + load-use
      idle(E_M2);
      add(0, 4'd0, 3'd0, 4'd0, 0, 0, 0, 0, 1, E_DEF);   // int_req pulse
      idle(E_D); idle(E_D); idle(E_D);
      idle(E_VEC);
      idle(E_DEF); idle(E_DEF);                         // no re-entry
      add(0, 4'd0, 3'd0, 4'd0, 0, 0, 0, 0, 1, E_DEF);   // interrupt, mem_multi in drain 2
      idle(E_D);
      add(0, 4'd0, 3'd0, 4'd0, 0, 0, 0, 1, 0, E_DMM);
      idle(E_M2D);
      idle(E_D);
      idle(E_VEC);
      idle(E_DEF);
      add(0, 4'd0, 3'd0, 4'd0, 0, 0, 0, 0, 1, E_DEF);   // interrupt, branch in drain
      add(0, 4'd0, 3'd0, 4'd0, 0, 0, 1, 0, 0, E_DBR);
      idle(E_D); idle(E_D);
      add(0, 4'd0, 3'd0, 4'd0, 0, 0, 0, 0, 1, E_VEC);   // request during ack
      idle(E_DEF);
      add(1, 4'd2, 3'd2, 4'd0, 1, 0, 0, 0, 0, E_D);     // load-use ignored in drain
      idle(E_D); idle(E_D);
      idle(E_VEC);
      idle(E_DEF);
      add(0, 4'd0, 3'd0, 4'd0, 0, 0, 0, 1, 1, E_MM);    // request with mem_multi in RUN
      idle(E_M2);
      idle(E_DEF);
      idle(E_D); idle(E_D); idle(E_D);
      idle(E_VEC);
      idle(E_DEF);

      z.mr = 0; z.dst = 0; z.s1 = 0; z.s2 = 0; z.u1 = 0; z.u2 = 0;
      z.br = 0; z.mm = 0; z.irq = 0; z.exp = E_DEF;
      drive(z);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      #1 check("reset_state", E_DEF);
      reset = 1'b1;

      for (int i = 0; i < tbl.size(); i++) begin
         @(negedge clk);
         drive(tbl[i]);
         #1 check($sformatf("vec%0d", i), tbl[i].exp);
      end

      // Reset asserted in the middle of an interrupt drain.
      @(negedge clk);
      z.irq = 1; drive(z);
      #1 check("mid_reset_req", E_DEF);
      @(negedge clk);
      z.irq = 0; drive(z);
      #1 check("mid_reset_drain", E_D);
      @(negedge clk);
      z.mm = 1; z.br = 1; drive(z);
      reset = 1'b0;
      #1 check("mid_reset_forced", E_DEF);
      @(negedge clk);
      #1 check("mid_reset_held", E_DEF);
      z.mm = 0; z.br = 0; drive(z);
      reset = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         #1 check($sformatf("post_reset%0d", i), E_DEF);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
